// File: rtl/theremin_pkg.sv
// Shared definitions for the note highway: default geometry, FSM states and
// the lane colour table used when plotting note cells.
package theremin_pkg;

  localparam int LANES_DEFAULT    = 4;
  localparam int ROWS_DEFAULT     = 8;
  localparam int SONG_LEN_DEFAULT = 128;

  typedef enum logic [2:0] {
    WAIT,
    FETCH,
    SHIFT,
    DRAW,
    DONE
  } hwState_t;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] BLUE   = 3'b001;
  localparam logic [2:0] YELLOW = 3'b110;

  // Lanes beyond the fourth reuse the palette cyclically.
  function automatic logic [2:0] laneColour(input int unsigned lane);
    case (lane % 4)
      0:       return RED;
      1:       return GREEN;
      2:       return BLUE;
      default: return YELLOW;
    endcase
  endfunction

endpackage

// File: rtl/note_highway_row_buffer.sv
// ROWS x LANES on-screen note array: synchronous clear, downward shift with a
// new top row, one random-access cell read port and the strike (bottom) row.
module note_row_buffer #(
  parameter int LANES = 4,
  parameter int ROWS  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       shift,
  input  logic [LANES-1:0]           topRow,
  input  logic [$clog2(LANES)-1:0]   cellX,
  input  logic [$clog2(ROWS)-1:0]    cellY,
  output logic                       cellBit,
  output logic [LANES-1:0]           bottomRow
);

  logic [LANES-1:0] rows [ROWS];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      for (int r = 0; r < ROWS; r++) rows[r] <= '0;
    end else if (shift) begin
      rows[0] <= topRow;
      for (int r = 1; r < ROWS; r++) rows[r] <= rows[r-1];
    end
  end

  assign cellBit   = rows[cellY][cellX];
  assign bottomRow = rows[ROWS-1];

endmodule

// File: rtl/note_highway.sv
// Note highway: per-beat ROM fetch, row shift and full-screen redraw over a
// valid/ready plot handshake. Optional scoring enabled with HIT_DETECT_EN.
module note_highway
  import theremin_pkg::*;
#(
  parameter int LANES    = LANES_DEFAULT,
  parameter int ROWS     = ROWS_DEFAULT,
  parameter int SONG_LEN = SONG_LEN_DEFAULT,
  parameter int ADDR_W   = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      shift_song,
  input  logic                      song_done,
  input  logic                      start_song,
  output logic                      ready_for_song,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [LANES-1:0]          rom_data,
  output logic                      draw_valid,
  input  logic                      draw_ready,
  output logic [$clog2(LANES)-1:0]  draw_x,
  output logic [$clog2(ROWS)-1:0]   draw_y,
  output logic [2:0]                draw_colour,
  output logic [LANES-1:0]          bottom_row
`ifdef HIT_DETECT_EN
  ,
  input  logic                      player_strobe,
  input  logic [LANES-1:0]          player_lane,
  output logic                      hit,
  output logic                      miss
`endif
);

  localparam int X_W = $clog2(LANES);
  localparam int Y_W = $clog2(ROWS);
  localparam logic [ADDR_W-1:0] SONG_END  = ADDR_W'(SONG_LEN);
  localparam logic [X_W-1:0]    LAST_X    = X_W'(LANES - 1);
  localparam logic [Y_W-1:0]    LAST_Y    = Y_W'(ROWS - 1);

  hwState_t state, stateNext;
  logic doClear, doShift, drawActive, readyOut, lastCell, cellBit;
  logic [X_W-1:0] xPtr;
  logic [Y_W-1:0] yPtr;
  logic [LANES-1:0] newRow;

  assign lastCell = (xPtr == LAST_X) && (yPtr == LAST_Y);

  always_ff @(posedge clock) begin
    if (reset) state <= WAIT;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    doClear    = 1'b0;
    doShift    = 1'b0;
    drawActive = 1'b0;
    readyOut   = 1'b0;
    case (state)
      WAIT: begin
        if (song_done) begin
          doClear  = 1'b1;
          readyOut = start_song;
        end
        if (shift_song) stateNext = FETCH;
      end
      FETCH: stateNext = SHIFT;
      SHIFT: begin
        doShift   = 1'b1;
        stateNext = DRAW;
      end
      DRAW: begin
        drawActive = 1'b1;
        if (draw_ready && lastCell) stateNext = DONE;
      end
      DONE: begin
        readyOut  = 1'b1;
        stateNext = WAIT;
      end
      default: stateNext = WAIT;
    endcase
  end

  // Address past the end of the song reads as silence so the tail scrolls off.
  always_ff @(posedge clock) begin
    if (reset || doClear)        rom_addr <= '0;
    else if (doShift && rom_addr != '1) rom_addr <= rom_addr + 1'b1;
  end

  assign newRow = (rom_addr >= SONG_END) ? '0 : rom_data;

  always_ff @(posedge clock) begin
    if (reset || doShift) begin
      xPtr <= '0;
      yPtr <= '0;
    end else if (drawActive && draw_ready) begin
      if (xPtr == LAST_X) begin
        xPtr <= '0;
        yPtr <= (yPtr == LAST_Y) ? '0 : yPtr + 1'b1;
      end else begin
        xPtr <= xPtr + 1'b1;
      end
    end
  end

  note_row_buffer #(
    .LANES (LANES),
    .ROWS  (ROWS)
  ) rowBuffer (
    .clock     (clock),
    .reset     (reset),
    .clear     (doClear),
    .shift     (doShift),
    .topRow    (newRow),
    .cellX     (xPtr),
    .cellY     (yPtr),
    .cellBit   (cellBit),
    .bottomRow (bottom_row)
  );

  assign ready_for_song = readyOut;
  assign draw_valid     = drawActive;
  assign draw_x         = xPtr;
  assign draw_y         = yPtr;
  assign draw_colour    = (drawActive && cellBit) ? laneColour(int'(xPtr)) : BLACK;

`ifdef HIT_DETECT_EN
  logic scored, hitNow;

  // Compares against the row currently registered, so a strobe in SHIFT
  // scores the row that is about to move off.
  assign hitNow = (bottom_row != '0) && (player_lane == bottom_row) && !scored;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit    <= 1'b0;
      miss   <= 1'b0;
      scored <= 1'b0;
    end else begin
      hit  <= player_strobe && hitNow;
      miss <= player_strobe && !hitNow;
      if (doShift || doClear)          scored <= 1'b0;
      else if (player_strobe && hitNow) scored <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_note_highway.sv
// Directed bench for note_highway: a default instance plus a short-song
// instance (SONG_LEN=2) driven in lockstep from a shared synchronous ROM.
module tb_note_highway;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, shift_song, song_done, start_song, draw_ready;
  logic       ready_for_song, draw_valid;
  logic [7:0] rom_addr;
  logic [3:0] rom_data, bottom_row;
  logic [1:0] draw_x;
  logic [2:0] draw_y, draw_colour;

  logic       readyShort, drawValidShort;
  logic [3:0] romAddrShort, romDataShort, bottomShort;
  logic [1:0] drawXShort;
  logic [2:0] drawYShort, drawColourShort;

`ifdef HIT_DETECT_EN
  logic       player_strobe, hit, miss, hitShort, missShort;
  logic [3:0] player_lane;
`endif

  note_highway dut (
    .clock(clock), .reset(reset), .shift_song(shift_song), .song_done(song_done),
    .start_song(start_song), .ready_for_song(ready_for_song), .rom_addr(rom_addr),
    .rom_data(rom_data), .draw_valid(draw_valid), .draw_ready(draw_ready),
    .draw_x(draw_x), .draw_y(draw_y), .draw_colour(draw_colour),
    .bottom_row(bottom_row)
`ifdef HIT_DETECT_EN
    , .player_strobe(player_strobe), .player_lane(player_lane), .hit(hit), .miss(miss)
`endif
  );

  note_highway #(.SONG_LEN(2), .ADDR_W(4)) dutShort (
    .clock(clock), .reset(reset), .shift_song(shift_song), .song_done(song_done),
    .start_song(start_song), .ready_for_song(readyShort), .rom_addr(romAddrShort),
    .rom_data(romDataShort), .draw_valid(drawValidShort), .draw_ready(draw_ready),
    .draw_x(drawXShort), .draw_y(drawYShort), .draw_colour(drawColourShort),
    .bottom_row(bottomShort)
`ifdef HIT_DETECT_EN
    , .player_strobe(player_strobe), .player_lane(player_lane), .hit(hitShort), .miss(missShort)
`endif
  );

  logic [3:0] rom [256];
  always @(posedge clock) begin
    rom_data     <= rom[rom_addr];
    romDataShort <= rom[{4'b0000, romAddrShort}];
  end

  int checks = 0;
  int failures = 0;
  logic [3:0] modelRows [8];
  logic [2:0] laneCol [4] = '{3'b100, 3'b010, 3'b001, 3'b110};

  function automatic logic [2:0] expColour(input int k);
    logic [3:0] row;
    row = modelRows[k / 4];
    return row[k % 4] ? laneCol[k % 4] : 3'b000;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic modelShift(input logic [3:0] top);
    for (int r = 7; r > 0; r--) modelRows[r] = modelRows[r-1];
    modelRows[0] = top;
  endtask

  task automatic modelClear();
    for (int r = 0; r < 8; r++) modelRows[r] = 4'b0000;
  endtask

  task automatic doBeat();
    logic got;
    draw_ready = 1'b1;
    shift_song = 1'b1;
    tick();
    shift_song = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (ready_for_song) got = 1'b1;
      else tick();
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL beat_timeout: ready_for_song never seen within 100 cycles");
    end
    tick();
  endtask

  task automatic clearSong();
    song_done = 1'b1;
    tick();
    song_done = 1'b0;
    modelClear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({ready_for_song, draw_valid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ctrl: got ready=%b valid=%b want 0 0", ready_for_song, draw_valid);
    end
    checks++;
    if (rom_addr !== 8'd0) begin
      failures++; $display("FAIL reset_addr: got %0d want 0", rom_addr);
    end
    checks++;
    if ({draw_x, draw_y, draw_colour} !== 8'd0) begin
      failures++;
      $display("FAIL reset_draw: got x=%0d y=%0d c=%b want 0 0 000", draw_x, draw_y, draw_colour);
    end
    checks++;
    if (bottom_row !== 4'b0000) begin
      failures++; $display("FAIL reset_bottom: got %b want 0000", bottom_row);
    end
    song_done  = 1'b1;
    start_song = 1'b1;
    #1;
    checks++;
    if (ready_for_song !== 1'b1 || draw_valid !== 1'b0 || rom_addr !== 8'd0) begin
      failures++;
      $display("FAIL start_grant: got ready=%b valid=%b addr=%0d want 1 0 0",
               ready_for_song, draw_valid, rom_addr);
    end
    start_song = 1'b0;
    #1;
    checks++;
    if (ready_for_song !== 1'b0) begin
      failures++; $display("FAIL start_release: got ready=%b want 0", ready_for_song);
    end
    tick();
    song_done = 1'b0;
    modelClear();
  endtask

  task automatic test_single_beat();
    draw_ready = 1'b1;
    shift_song = 1'b1;
    tick();
    shift_song = 1'b0;
    checks++;
    if (draw_valid !== 1'b0) begin
      failures++; $display("FAIL latency_fetch: got valid=%b want 0", draw_valid);
    end
    tick();
    checks++;
    if (draw_valid !== 1'b0) begin
      failures++; $display("FAIL latency_shift: got valid=%b want 0", draw_valid);
    end
    tick();
    checks++;
    if (draw_valid !== 1'b1) begin
      failures++; $display("FAIL latency_draw: got valid=%b want 1", draw_valid);
    end
    modelShift(4'b0001);
    for (int k = 0; k < 32; k++) begin
      checks++;
      if ({draw_valid, draw_y, draw_x, draw_colour} !== {1'b1, 3'(k / 4), 2'(k % 4), expColour(k)}) begin
        failures++;
        $display("FAIL cell_%0d: got v=%b y=%0d x=%0d c=%b want v=1 y=%0d x=%0d c=%b",
                 k, draw_valid, draw_y, draw_x, draw_colour, k / 4, k % 4, expColour(k));
      end
      checks++;
      if (ready_for_song !== 1'b0) begin
        failures++; $display("FAIL early_ready_%0d: got %b want 0", k, ready_for_song);
      end
      tick();
    end
    checks++;
    if (ready_for_song !== 1'b1 || draw_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: got ready=%b valid=%b want 1 0", ready_for_song, draw_valid);
    end
    tick();
    checks++;
    if (ready_for_song !== 1'b0 || rom_addr !== 8'd1 || bottom_row !== 4'b0000) begin
      failures++;
      $display("FAIL after_beat: got ready=%b addr=%0d bottom=%b want 0 1 0000",
               ready_for_song, rom_addr, bottom_row);
    end
  endtask

  task automatic test_backpressure();
    int k;
    logic done;
    shift_song = 1'b1;
    tick();
    shift_song = 1'b0;
    tick();
    tick();
    modelShift(4'b1010);
    k = 0;
    done = 1'b0;
    draw_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      draw_ready = ~draw_ready;
      checks++;
      if ({draw_valid, draw_y, draw_x, draw_colour} !== {1'b1, 3'(k / 4), 2'(k % 4), expColour(k)}) begin
        failures++;
        $display("FAIL bp_cell_%0d: got v=%b y=%0d x=%0d c=%b want v=1 y=%0d x=%0d c=%b",
                 k, draw_valid, draw_y, draw_x, draw_colour, k / 4, k % 4, expColour(k));
      end
      if (draw_ready) k++;
      if (k == 32) done = 1'b1;
      tick();
    end
    draw_ready = 1'b1;
    checks++;
    if (!done || ready_for_song !== 1'b1) begin
      failures++;
      $display("FAIL bp_done: got handshakes=%0d ready=%b want 32 1", k, ready_for_song);
    end
    tick();
    checks++;
    if (ready_for_song !== 1'b0 || draw_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle: got ready=%b valid=%b want 0 0", ready_for_song, draw_valid);
    end
  endtask

  task automatic test_scroll_flush();
    logic [3:0] pattern [10] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'hF, 4'hF};
    for (int i = 0; i < 10; i++) rom[i] = pattern[i];
    clearSong();
    for (int i = 0; i < 8; i++) doBeat();
    checks++;
    if (bottom_row !== 4'b0001 || rom_addr !== 8'd8) begin
      failures++;
      $display("FAIL eight_beats: got bottom=%b addr=%0d want 0001 8", bottom_row, rom_addr);
    end
    checks++;
    if (bottomShort !== 4'b0001 || romAddrShort !== 4'd8) begin
      failures++;
      $display("FAIL short_eight: got bottom=%b addr=%0d want 0001 8", bottomShort, romAddrShort);
    end
    doBeat();
    checks++;
    if (bottomShort !== 4'b0010 || bottom_row !== 4'b0010) begin
      failures++;
      $display("FAIL ninth_beat: got short=%b main=%b want 0010 0010", bottomShort, bottom_row);
    end
    doBeat();
    checks++;
    if (bottomShort !== 4'b0000 || romAddrShort !== 4'd10) begin
      failures++;
      $display("FAIL flush_empty: got bottom=%b addr=%0d want 0000 10", bottomShort, romAddrShort);
    end
    checks++;
    if (bottom_row !== 4'b0100) begin
      failures++; $display("FAIL main_tenth: got %b want 0100", bottom_row);
    end
  endtask

`ifdef HIT_DETECT_EN
  task automatic strobe(input logic [3:0] lane);
    player_lane   = lane;
    player_strobe = 1'b1;
    tick();
    player_strobe = 1'b0;
  endtask

  task automatic test_hit_detect();
    for (int i = 0; i < 16; i++) rom[i] = 4'b0000;
    rom[0] = 4'b0010;
    rom[1] = 4'b0100;
    clearSong();
    for (int i = 0; i < 8; i++) doBeat();
    checks++;
    if (bottom_row !== 4'b0010) begin
      failures++; $display("FAIL hit_setup: got %b want 0010", bottom_row);
    end
    strobe(4'b0010);
    checks++;
    if ({hit, miss} !== 2'b10) begin
      failures++; $display("FAIL first_hit: got hit=%b miss=%b want 1 0", hit, miss);
    end
    tick();
    checks++;
    if ({hit, miss} !== 2'b00) begin
      failures++; $display("FAIL hit_pulse: got hit=%b miss=%b want 0 0", hit, miss);
    end
    strobe(4'b0010);
    checks++;
    if ({hit, miss} !== 2'b01) begin
      failures++; $display("FAIL rescore_miss: got hit=%b miss=%b want 0 1", hit, miss);
    end
    doBeat();
    strobe(4'b0001);
    checks++;
    if ({hit, miss} !== 2'b01) begin
      failures++; $display("FAIL wrong_lane: got hit=%b miss=%b want 0 1", hit, miss);
    end
    strobe(4'b0100);
    checks++;
    if ({hit, miss} !== 2'b10) begin
      failures++; $display("FAIL new_row_hit: got hit=%b miss=%b want 1 0", hit, miss);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 4'b0000;
    rom[0] = 4'b0001;
    rom[1] = 4'b1010;
    reset = 1'b1; shift_song = 1'b0; song_done = 1'b0; start_song = 1'b0; draw_ready = 1'b1;
`ifdef HIT_DETECT_EN
    player_strobe = 1'b0;
    player_lane   = 4'b0000;
`endif
    modelClear();
    test_reset();
    test_single_beat();
    test_backpressure();
    test_scroll_flush();
`ifdef HIT_DETECT_EN
    test_hit_detect();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_highway.md
Name: note_highway

Overview:
- Downstream of the song sequencer FSM. Consumes its one-cycle shift_song pulse and its song_done level.
- On each beat, fetches the next note row from the song ROM and shifts it into a ROWS x LANES on-screen note array.
- Streams every cell to the VGA plotter over a valid/ready handshake, then pulses ready_for_song back to the sequencer.
- Exposes the bottom (strike) row for scoring.

Parameters:
LANES, 4, note lanes per row (one ROM data bit per lane)
ROWS, 8, visible rows in the highway
SONG_LEN, 128, song rows in ROM; addresses at or above SONG_LEN read as empty rows
ADDR_W, 8, ROM address width; must satisfy 2^ADDR_W >= SONG_LEN+ROWS

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
shift_song  in  1  one-cycle beat pulse from sequencer
song_done  in  1  sequencer idle/finished level
start_song  in  1  user start request
ready_for_song  out  1  to sequencer: start grant / screen-drawn pulse
rom_addr  out  ADDR_W  song ROM address (registered)
rom_data  in  LANES  song ROM row, valid 1 cycle after rom_addr
draw_valid  out  1  plot request
draw_ready  in  1  plotter accepts
draw_x  out  clog2(LANES)  lane index of cell
draw_y  out  clog2(ROWS)  row index of cell, 0 = top
draw_colour  out  3  lane colour if note present, 3'b000 if empty
bottom_row  out  LANES  contents of row ROWS-1

Behaviour:
- Reset values: state WAIT, array all 0, rom_addr 0, draw_valid 0, draw_x/draw_y/draw_colour 0, ready_for_song 0.
- States: WAIT, FETCH, SHIFT, DRAW, DONE.
- WAIT:
  - If song_done=1: array cleared, rom_addr reset to 0, ready_for_song = start_song (combinational level).
  - If shift_song=1: go to FETCH. shift_song in any other state is ignored.
- FETCH: one cycle. rom_addr is already stable; rom_data is sampled next cycle.
- SHIFT: one cycle.
  - row[r] <= row[r-1] for r=1..ROWS-1; row[0] <= rom_data, or 0 if rom_addr >= SONG_LEN.
  - rom_addr increments, saturating at 2^ADDR_W-1.
  - Cell pointer cleared; go to DRAW.
- DRAW:
  - Cells are visited row-major: y=0..ROWS-1, x=0..LANES-1. draw_valid=1 throughout.
  - draw_x, draw_y and draw_colour are held stable until draw_ready is sampled high; the pointer advances on valid&ready.
  - Handshake on cell (ROWS-1, LANES-1) -> DONE. With draw_ready tied high, DRAW lasts exactly ROWS*LANES cycles.
- DONE: ready_for_song=1 for exactly one cycle, draw_valid=0 -> WAIT.
- Latency: shift_song pulse to first draw_valid = 3 cycles; DONE to ready_for_song is the same cycle.
- Flush: after SONG_LEN rows, empty rows keep shifting in so the last notes scroll off. Song end is owned by the sequencer.
- Reset mid-DRAW: draw_valid drops on the next edge; no further ready_for_song.
- bottom_row is row[ROWS-1], registered, and updates only in SHIFT.

Optional Feature:
- Macro: HIT_DETECT_EN.
- With HIT_DETECT_EN, add ports:
  - player_strobe in 1, player_lane in LANES
  - hit out 1, miss out 1 (one-cycle pulses, reset 0)
- On player_strobe:
  - hit if bottom_row != 0, player_lane == bottom_row, and the row is not yet scored; otherwise miss.
  - A scored flag blocks further hits on that row and is cleared in SHIFT.
  - A strobe in the SHIFT cycle compares against the pre-shift row.
- Without the macro: ports absent, no scoring logic.

Decomposition:
- Package theremin_pkg: LANES, ROWS, SONG_LEN defaults; state enum; lane colour table (lane0 red 3'b100, lane1 green 3'b010, lane2 blue 3'b001, lane3 yellow 3'b110); BLACK constant.
- One sub-module, note_row_buffer: the shift array with clear, shift, load-top and cell-read port. The FSM, address counter and draw pointer stay in note_highway.

Test Plan:
- Reset, then song_done=1, start_song=1 -> ready_for_song=1 same cycle; rom_addr=0; draw_valid=0.
- ROM row0=4'b0001, draw_ready=1, one shift_song pulse -> draw_valid 3 cycles later; 32 cells; cell (0,0) colour 3'b100, all others 3'b000; ready_for_song pulses once after the last cell.
- draw_ready toggled 1-0-1 every other cycle -> each cell held stable until accepted; exactly 32 handshakes; ready_for_song after 32nd.
- 8 beats with rows 1,2,4,8,... -> bottom_row=4'b0001 after 8th SHIFT; rom_addr=8.
- SONG_LEN=2, 10 beats -> rows 3..10 shift in as 0; bottom_row=0 after 10th beat.
- HIT_DETECT_EN: bottom_row=4'b0010, two strobes with player_lane=4'b0010 -> hit then miss; after next SHIFT, strobe with a matching lane -> hit again.
